// File: rtl/i2c_bus_cond_detect_pkg.sv
// Shared types and default parameters for the I2C bus condition detector.
// Holds the bus ownership state enum and the synchroniser/filter default depths.
package i2c_bus_pkg;

   typedef enum logic {
      IDLE,
      BUSY
   } bus_state_t;

   localparam int I2C_SYNC_STAGES = 2;
   localparam int I2C_FILT_CYCLES = 3;

endpackage

// File: rtl/i2c_bus_cond_detect_if.sv
// Bus-side signal bundle of the I2C condition detector.
// slave: detector view (pad levels in, filtered levels/pulses out); master: the driver/consumer view.
interface i2c_bus_cond_detect_if;

   logic SCL_IN;
   logic SDA_IN;
   logic SCL_F;
   logic SDA_F;
   logic SCL_RISE;
   logic SCL_FALL;
   logic START_DET;
   logic STOP_DET;
   logic BUS_BUSY;

   modport master (
      output SCL_IN, SDA_IN,
      input  SCL_F, SDA_F, SCL_RISE, SCL_FALL,
      input  START_DET, STOP_DET, BUS_BUSY
   );

   modport slave (
      input  SCL_IN, SDA_IN,
      output SCL_F, SDA_F, SCL_RISE, SCL_FALL,
      output START_DET, STOP_DET, BUS_BUSY
   );

endinterface

// File: rtl/i2c_bus_cond_detect_line_filter.sv
// One I2C line: synchroniser, stable-count spike filter, filtered (f_o) and previous (p_o) levels.
// Ports: clk_i, rst_ni (async low), line_i (async pad level), f_o (filtered), p_o (f_o one cycle ago).
module i2c_line_filter
   import i2c_bus_pkg::*;
#(
   parameter int SYNC_STAGES = I2C_SYNC_STAGES,
   parameter int FILT_CYCLES = I2C_FILT_CYCLES
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic line_i,
   output logic f_o,
   output logic p_o
);

   localparam int CNT_W = $clog2(FILT_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FILT_CYCLES - 1);

   logic [SYNC_STAGES-1:0] sync_q;
   logic [SYNC_STAGES-1:0] sync_d;
   logic [CNT_W-1:0]       cnt_q;
   logic [CNT_W-1:0]       cnt_d;
   logic                   f_q;
   logic                   f_d;
   logic                   p_q;
   logic                   s;

   assign s      = sync_q[SYNC_STAGES-1];
   assign sync_d = {sync_q[SYNC_STAGES-2:0], line_i};

   // A new level is accepted only after FILT_CYCLES consecutive
   // samples that differ from the current filtered level.
   always_comb begin
      f_d   = f_q;
      cnt_d = cnt_q;
      if (s == f_q) begin
         cnt_d = '0;
      end else if (cnt_q == CNT_MAX) begin
         f_d   = s;
         cnt_d = '0;
      end else begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sync_q <= '1;
         cnt_q  <= '0;
         f_q    <= 1'b1;
         p_q    <= 1'b1;
      end else begin
         sync_q <= sync_d;
         cnt_q  <= cnt_d;
         f_q    <= f_d;
         p_q    <= f_q;
      end
   end

   assign f_o = f_q;
   assign p_o = p_q;

endmodule

// File: rtl/i2c_bus_cond_detect.sv
// I2C bus condition detector: filtered SCL/SDA, SCL edge pulses, START/STOP pulses, bus busy flag.
// Ports: CLK, RSTN (async low), bus (slave modport: SCL_IN/SDA_IN in; SCL_F, SDA_F, pulses, BUS_BUSY out).
module i2c_bus_cond_detect
   import i2c_bus_pkg::*;
#(
   parameter int SYNC_STAGES = I2C_SYNC_STAGES,
   parameter int FILT_CYCLES = I2C_FILT_CYCLES
) (
   input  logic                  CLK,
   input  logic                  RSTN,
   i2c_bus_cond_detect_if.slave  bus
);

   logic scl_f;
   logic scl_p;
   logic sda_f;
   logic sda_p;

   logic rise_d;
   logic fall_d;
   logic start_d;
   logic stop_d;

   logic rise_q;
   logic fall_q;
   logic start_q;
   logic stop_q;

   bus_state_t state_q;
   bus_state_t state_d;

   i2c_line_filter #(
      .SYNC_STAGES (SYNC_STAGES),
      .FILT_CYCLES (FILT_CYCLES)
   ) u_scl (
      .clk_i  (CLK),
      .rst_ni (RSTN),
      .line_i (bus.SCL_IN),
      .f_o    (scl_f),
      .p_o    (scl_p)
   );

   i2c_line_filter #(
      .SYNC_STAGES (SYNC_STAGES),
      .FILT_CYCLES (FILT_CYCLES)
   ) u_sda (
      .clk_i  (CLK),
      .rst_ni (RSTN),
      .line_i (bus.SDA_IN),
      .f_o    (sda_f),
      .p_o    (sda_p)
   );

   // SCL must be high both before and after the SDA change, so an
   // SDA change coincident with an SCL edge is never a condition.
   assign rise_d  = scl_f & ~scl_p;
   assign fall_d  = ~scl_f & scl_p;
   assign start_d = sda_p & ~sda_f & scl_p & scl_f;
   assign stop_d  = ~sda_p & sda_f & scl_p & scl_f;

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: if (start_d) state_d = BUSY;
         BUSY: if (stop_d)  state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         rise_q  <= 1'b0;
         fall_q  <= 1'b0;
         start_q <= 1'b0;
         stop_q  <= 1'b0;
      end else begin
         rise_q  <= rise_d;
         fall_q  <= fall_d;
         start_q <= start_d;
         stop_q  <= stop_d;
      end
   end

   assign bus.SCL_F     = scl_f;
   assign bus.SDA_F     = sda_f;
   assign bus.SCL_RISE  = rise_q;
   assign bus.SCL_FALL  = fall_q;
   assign bus.START_DET = start_q;
   assign bus.STOP_DET  = stop_q;
   assign bus.BUS_BUSY  = (state_q == BUSY);

endmodule

// File: tb/tb_i2c_bus_cond_detect.sv
// Scoreboard bench for i2c_bus_cond_detect (SYNC_STAGES=2, FILT_CYCLES=3).
// Stimulus pushes expected pulse events; a forked monitor pops them as pulses appear.
module tb_i2c_bus_cond_detect;

   logic CLK  = 1'b0;
   logic RSTN = 1'b1;

   i2c_bus_cond_detect_if bus_if ();

   i2c_bus_cond_detect #(
      .SYNC_STAGES (2),
      .FILT_CYCLES (3)
   ) dut (
      .CLK  (CLK),
      .RSTN (RSTN),
      .bus  (bus_if)
   );

   always #5 CLK = ~CLK;

   typedef struct packed {
      logic start;
      logic stop;
      logic rise;
      logic fall;
      logic busy;
   } ev_t;

   ev_t  exp_q[$];
   int   n_chk  = 0;
   int   n_fail = 0;
   logic cur_scl;
   logic cur_sda;
   logic exp_busy;

   task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Pulse order {start,stop,rise,fall,busy}
   task automatic monitor();
      ev_t got;
      ev_t e;
      forever begin
         @(negedge CLK);
         if (RSTN) begin
            got = {bus_if.START_DET, bus_if.STOP_DET,
                   bus_if.SCL_RISE, bus_if.SCL_FALL, bus_if.BUS_BUSY};
            if (got[4:1] != 4'b0) begin
               if (exp_q.size() == 0) begin
                  check("unexpected_pulse", 32'(got), 32'h0);
               end else begin
                  e = exp_q.pop_front();
                  check("pulse_event", 32'(got), 32'(e));
               end
            end
         end
      end
   endtask

   // Expected I2C semantics from pad-level changes held long enough
   task automatic apply(logic scl, logic sda, int hold);
      ev_t e;
      e.rise  = scl & ~cur_scl;
      e.fall  = ~scl & cur_scl;
      e.start = cur_scl & scl & cur_sda & ~sda;
      e.stop  = cur_scl & scl & ~cur_sda & sda;
      if (e.start) exp_busy = 1'b1;
      if (e.stop)  exp_busy = 1'b0;
      e.busy = exp_busy;
      if (e.rise | e.fall | e.start | e.stop) exp_q.push_back(e);
      @(posedge CLK);
      #1;
      bus_if.SCL_IN = scl;
      bus_if.SDA_IN = sda;
      cur_scl = scl;
      cur_sda = sda;
      repeat (hold) @(posedge CLK);
   endtask

   task automatic glitch_scl(int len);
      ev_t e;
      logic all_hi;
      if (len >= 3) begin
         e = '{start: 1'b0, stop: 1'b0, rise: 1'b0, fall: 1'b1, busy: exp_busy};
         exp_q.push_back(e);
         e = '{start: 1'b0, stop: 1'b0, rise: 1'b1, fall: 1'b0, busy: exp_busy};
         exp_q.push_back(e);
      end
      @(posedge CLK);
      #1 bus_if.SCL_IN = 1'b0;
      repeat (len) @(posedge CLK);
      #1 bus_if.SCL_IN = 1'b1;
      all_hi = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(posedge CLK);
         #1 all_hi = all_hi & bus_if.SCL_F;
      end
      if (len < 3) check("glitch_scl_f_held", 32'(all_hi), 32'h1);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [8:0] bits;
      bits = 9'h14A;
      bus_if.SCL_IN = 1'b1;
      bus_if.SDA_IN = 1'b1;
      cur_scl  = 1'b1;
      cur_sda  = 1'b1;
      exp_busy = 1'b0;
      fork
         monitor();
      join_none

      // 1: reset state, SCL low during reset has no effect
      #2 RSTN = 1'b0;
      #1;
      check("rst_scl_f", 32'(bus_if.SCL_F), 32'h1);
      check("rst_sda_f", 32'(bus_if.SDA_F), 32'h1);
      check("rst_busy", 32'(bus_if.BUS_BUSY), 32'h0);
      check("rst_pulses", 32'({bus_if.SCL_RISE, bus_if.SCL_FALL,
            bus_if.START_DET, bus_if.STOP_DET}), 32'h0);
      @(posedge CLK);
      #1 bus_if.SCL_IN = 1'b0;
      repeat (2) @(posedge CLK);
      #1 bus_if.SCL_IN = 1'b1;
      check("rst_scl_hold", 32'(bus_if.SCL_F), 32'h1);
      repeat (2) @(posedge CLK);
      #1 RSTN = 1'b1;
      repeat (5) @(posedge CLK);

      // 2: START latency then STOP
      apply(1'b1, 1'b0, 0);
      repeat (4) @(posedge CLK);
      #1 check("sda_f_lat4", 32'(bus_if.SDA_F), 32'h1);
      @(posedge CLK);
      #1 check("sda_f_lat5", 32'(bus_if.SDA_F), 32'h0);
      check("busy_pre_start", 32'(bus_if.BUS_BUSY), 32'h0);
      @(posedge CLK);
      #1 check("busy_post_start", 32'(bus_if.BUS_BUSY), 32'h1);
      repeat (4) @(posedge CLK);
      apply(1'b1, 1'b1, 8);

      // 3: SCL glitches
      glitch_scl(2);
      glitch_scl(3);

      // 4: full byte plus ACK
      apply(1'b1, 1'b0, 8);
      for (int i = 8; i >= 0; i--) begin
         apply(1'b0, bits[i], 8);
         apply(1'b1, bits[i], 8);
      end
      apply(1'b0, 1'b0, 8);
      apply(1'b1, 1'b0, 8);
      apply(1'b1, 1'b1, 8);

      // 5: repeated START, simultaneous SCL/SDA changes
      apply(1'b1, 1'b0, 8);
      apply(1'b0, 1'b1, 8);
      apply(1'b1, 1'b1, 8);
      apply(1'b1, 1'b0, 8);
      apply(1'b0, 1'b1, 8);
      apply(1'b1, 1'b0, 8);
      check("busy_after_rstart", 32'(bus_if.BUS_BUSY), 32'h1);
      apply(1'b1, 1'b1, 8);

      // stray STOP while idle
      apply(1'b0, 1'b1, 8);
      apply(1'b0, 1'b0, 8);
      apply(1'b1, 1'b0, 8);
      apply(1'b1, 1'b1, 8);
      check("busy_after_stray", 32'(bus_if.BUS_BUSY), 32'h0);

      // 6: reset mid-byte, resume without START
      apply(1'b1, 1'b0, 8);
      apply(1'b0, 1'b1, 8);
      apply(1'b1, 1'b1, 8);
      apply(1'b0, 1'b0, 8);
      @(posedge CLK);
      #1 check("busy_before_rst", 32'(bus_if.BUS_BUSY), 32'h1);
      RSTN = 1'b0;
      #1 check("busy_async_clr", 32'(bus_if.BUS_BUSY), 32'h0);
      repeat (3) @(posedge CLK);
      #1 RSTN = 1'b1;
      cur_scl  = 1'b1;
      cur_sda  = 1'b1;
      exp_busy = 1'b0;
      apply(1'b0, 1'b0, 8);
      apply(1'b1, 1'b0, 8);
      apply(1'b0, 1'b1, 8);
      apply(1'b1, 1'b1, 8);
      check("busy_after_resume", 32'(bus_if.BUS_BUSY), 32'h0);

      repeat (10) @(posedge CLK);
      check("queue_empty", 32'(exp_q.size()), 32'h0);
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
